pwm_ramp_ctrl: RTL and testbench

Duty-cycle sequencer for the 8-bit `pwm` block: accepts target-duty commands over a valid/ready handshake and ramps the `pwm` `din` value toward the target in fixed steps. Duty changes are applied only at 256-clock period boundaries, so the PWM output never sees a mid-period duty change. It sits between the register/command logic and the `pwm` instance; its `duty` output drives `pwm.din` directly.

---
 rtl/pwm_ramp_ctrl.sv | 126 ++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps the 8-bit PWM duty toward commanded targets, changing it only at 256-clock period boundaries.
// Define PWM_CTRL_STOP_EN to add the stop_req soft-stop (ramp down to 0).
module pwm_ramp_ctrl #(
    parameter int unsigned RAMP_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_target,
    input  logic [7:0] cmd_step,
`ifdef PWM_CTRL_STOP_EN
    input  logic       stop_req,
`endif
    output logic [7:0] duty,
    output logic       period_start,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_q;
    logic [7:0] div_q, div_d;
    logic [7:0] target_q, target_d;
    logic [7:0] step_q, step_d;
    logic [7:0] duty_d;
    logic       done_d;

    logic       stop;
    logic       boundary, step_fire;
    logic       dir_down;
    logic [7:0] tgt_eff;
    logic [8:0] sum, diff;
    logic [7:0] up_val, dn_val;

`ifdef PWM_CTRL_STOP_EN
    assign stop = stop_req;
`else
    assign stop = 1'b0;
`endif

    assign boundary     = (phase_q == 8'hFF);
    assign step_fire    = boundary && (div_q == DIV_LAST);
    assign period_start = (phase_q == 8'h00);
    assign busy         = (state_q != IDLE);
    assign cmd_ready    = !busy;

    // A stop arriving mid-ramp retargets the step taken in the same cycle toward 0.
    assign tgt_eff  = stop ? 8'h00 : target_q;
    assign dir_down = stop || (state_q == DOWN);
    assign sum      = {1'b0, duty} + {1'b0, step_q};
    assign diff     = {1'b0, duty} - {1'b0, step_q};
    assign up_val   = ((step_q == 8'h00) || (sum > {1'b0, tgt_eff})) ? tgt_eff : sum[7:0];
    assign dn_val   = ((step_q == 8'h00) || diff[8] || (diff[7:0] < tgt_eff)) ? tgt_eff : diff[7:0];

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        target_d = target_q;
        step_d   = step_q;
        duty_d   = duty;
        done_d   = 1'b0;

        if (boundary)
            div_d = step_fire ? '0 : div_q + 8'd1;

        if (state_q == IDLE) begin
            if (stop) begin
                target_d = '0;
                step_d   = 8'd1;
                div_d    = '0;
                if (duty == 8'h00)
                    done_d = 1'b1;
                else
                    state_d = DOWN;
            end else if (cmd_valid) begin
                target_d = cmd_target;
                step_d   = cmd_step;
                div_d    = '0;
                if (cmd_target > duty)
                    state_d = UP;
                else if (cmd_target < duty)
                    state_d = DOWN;
                else
                    done_d = 1'b1;
            end
        end else begin
            if (stop) begin
                target_d = '0;
                state_d  = DOWN;
            end
            if (step_fire) begin
                duty_d = dir_down ? dn_val : up_val;
                if (duty_d == tgt_eff) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            div_q    <= '0;
            target_q <= '0;
            step_q   <= '0;
            duty     <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_q + 8'd1;
            div_q    <= div_d;
            target_q <= target_d;
            step_q   <= step_d;
            duty     <= duty_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected duty changes and done events are queued at stimulus time
// and checked by monitors as the DUT produces them.
module tb_pwm_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, busy, done, period_start;
    logic [7:0] cmd_target, cmd_step, duty;
    logic       cmd4_valid, cmd4_ready, busy4, done4, period_start4;
    logic [7:0] cmd4_target, cmd4_step, duty4;
`ifdef PWM_CTRL_STOP_EN
    logic       stop_req;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0] q_duty[$];
    logic [7:0] q_done[$];
    logic [7:0] last_duty = 8'h00;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.RAMP_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step),
`ifdef PWM_CTRL_STOP_EN
        .stop_req(stop_req),
`endif
        .duty(duty), .period_start(period_start), .busy(busy), .done(done)
    );

    pwm_ramp_ctrl #(.RAMP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd4_valid), .cmd_ready(cmd4_ready),
        .cmd_target(cmd4_target), .cmd_step(cmd4_step),
`ifdef PWM_CTRL_STOP_EN
        .stop_req(1'b0),
`endif
        .duty(duty4), .period_start(period_start4), .busy(busy4), .done(done4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // duty monitor: every change must be the next queued value and land on a phase==0 cycle
    always @(negedge clk) begin
        if (duty !== last_duty) begin
            if (q_duty.size() == 0)
                check_eq("duty_unexpected", {24'd0, duty}, {24'd0, last_duty});
            else
                check_eq("duty_step", {24'd0, duty}, {24'd0, q_duty.pop_front()});
            check_eq("duty_at_phase0", {31'd0, period_start}, 32'd1);
            last_duty = duty;
        end
        if (done === 1'b1) begin
            if (q_done.size() == 0)
                check_eq("done_unexpected", 32'd1, 32'd0);
            else
                check_eq("done_duty", {24'd0, duty}, {24'd0, q_done.pop_front()});
            check_eq("busy_at_done", {31'd0, busy}, 32'd0);
        end
    end

    task automatic send_cmd(input logic [7:0] tgt, input logic [7:0] stp);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) check_eq("send_timeout", 32'd1, 32'd0);
        cmd_valid  = 1'b1;
        cmd_target = tgt;
        cmd_step   = stp;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (q_duty.size() == 0 && q_done.size() == 0 && !busy) begin ok = 1; break; end
        end
        if (!ok) check_eq(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_duty(input logic [7:0] val);
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (duty == val) begin ok = 1; break; end
        end
        if (!ok) check_eq("wait_duty_timeout", {24'd0, duty}, {24'd0, val});
    endtask

    initial begin
        int cnt;
        bit ok;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0;
        cmd4_valid = 1'b0; cmd4_target = '0; cmd4_step = '0;
`ifdef PWM_CTRL_STOP_EN
        stop_req = 1'b0;
`endif

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_duty", {24'd0, duty}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_pstart", {31'd0, period_start}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        // period_start spacing
        for (int k = 0; k < 2; k++) begin
            cnt = 0;
            ok = 0;
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                cnt++;
                if (period_start) begin ok = 1; break; end
            end
            if (!ok) cnt = 0;
            check_eq("pstart_period", cnt, 256);
        end

        // ramp up, RAMP_DIV=1
        q_duty.push_back(8'd30); q_duty.push_back(8'd60);
        q_duty.push_back(8'd90); q_duty.push_back(8'd100);
        q_done.push_back(8'd100);
        send_cmd(8'd100, 8'd30);
        wait_drain("rampup_timeout");

        // ramp down with clamp, then same-target command
        q_duty.push_back(8'd60); q_duty.push_back(8'd20); q_duty.push_back(8'd5);
        q_done.push_back(8'd5);
        send_cmd(8'd5, 8'd40);
        wait_drain("rampdown_timeout");
        q_done.push_back(8'd5);
        send_cmd(8'd5, 8'd9);
        @(negedge clk);
        check_eq("same_tgt_done", {31'd0, done}, 32'd1);
        check_eq("same_tgt_busy", {31'd0, busy}, 32'd0);
        wait_drain("same_tgt_timeout");

        // accept on the boundary cycle: no step there, change one period later
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (period_start) begin ok = 1; break; end
        end
        repeat (255) @(negedge clk);
        q_duty.push_back(8'd20);
        q_done.push_back(8'd20);
        cmd_valid = 1'b1; cmd_target = 8'd20; cmd_step = 8'd20;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cnt = 0;
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (period_start) cnt++;
            if (duty != 8'd5) begin ok = 1; break; end
        end
        check_eq("bnd_accept_periods", ok ? cnt : 0, 2);
        wait_drain("bnd_timeout");

        // step 0 on RAMP_DIV=4: jump at the 4th boundary
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (period_start4) begin ok = 1; break; end
        end
        cmd4_valid = 1'b1; cmd4_target = 8'd200; cmd4_step = 8'd0;
        @(posedge clk);
        #1 cmd4_valid = 1'b0;
        cnt = 0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (period_start4) cnt++;
            if (duty4 != 8'd0) begin ok = 1; break; end
        end
        check_eq("div4_periods", ok ? cnt : 0, 4);
        check_eq("div4_duty", {24'd0, duty4}, 32'd200);
        check_eq("div4_at_phase0", {31'd0, period_start4}, 32'd1);
        check_eq("div4_done", {31'd0, done4}, 32'd1);

        // hold-off: command held during a ramp is taken as busy falls
        q_duty.push_back(8'd70); q_duty.push_back(8'd120);
        q_duty.push_back(8'd170); q_duty.push_back(8'd200);
        q_done.push_back(8'd200);
        q_duty.push_back(8'd50);
        q_done.push_back(8'd50);
        send_cmd(8'd200, 8'd50);
        cmd_valid = 1'b1; cmd_target = 8'd50; cmd_step = 8'd0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
            if (i < 3) check_eq("holdoff_busy", {31'd0, busy}, 32'd1);
        end
        check_eq("held_accept_at_done", ok ? {31'd0, done} : 32'd0, 32'd1);
        check_eq("held_duty_at_accept", {24'd0, duty}, 32'd200);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_drain("held_timeout");

        // reset mid-ramp
        q_duty.push_back(8'd60); q_duty.push_back(8'd70);
        send_cmd(8'd250, 8'd10);
        wait_duty(8'd70);
        q_duty.push_back(8'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_duty", {24'd0, duty}, 32'd0);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef PWM_CTRL_STOP_EN
        // soft stop mid-ramp, simultaneous command ignored
        q_duty.push_back(8'd30); q_duty.push_back(8'd60); q_duty.push_back(8'd90);
        send_cmd(8'd200, 8'd30);
        wait_duty(8'd90);
        q_duty.push_back(8'd60); q_duty.push_back(8'd30); q_duty.push_back(8'd0);
        q_done.push_back(8'd0);
        stop_req = 1'b1; cmd_valid = 1'b1; cmd_target = 8'd255; cmd_step = 8'd1;
        @(posedge clk);
        #1 stop_req = 1'b0; cmd_valid = 1'b0;
        wait_drain("stop_timeout");

        // stop at duty 0 from IDLE beats a simultaneous command
        q_done.push_back(8'd0);
        @(negedge clk);
        stop_req = 1'b1; cmd_valid = 1'b1; cmd_target = 8'd100; cmd_step = 8'd10;
        @(posedge clk);
        #1 stop_req = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("stop0_done", {31'd0, done}, 32'd1);
        check_eq("stop0_busy", {31'd0, busy}, 32'd0);
        repeat (600) @(negedge clk);
        check_eq("stop0_duty", {24'd0, duty}, 32'd0);
`endif

        repeat (300) @(negedge clk);
        check_eq("duty_q_left", q_duty.size(), 0);
        check_eq("done_q_left", q_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
